regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_register.sv | 15 +
 rtl/regfile.sv | 36 +++
 tb/tb_regfile.sv | 128 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared datapath constants (default width, index width, hardwired zero index)
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_register.sv
// register: WIDTH-bit storage word; ports clock, reset (sync, active-high), load, d in, q out
module register #(
  parameter int WIDTH = regfile_pkg::DATA_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d, q_q;
  always_comb q_d = load ? d : q_q;
  always_ff @(posedge clock) q_q <= reset ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/regfile.sv
// regfile: 2-read/1-write register file, r0 hardwired zero; ports clock, reset, rsNum/rtNum read indices, rdNum/rdData/rdWriteEnable write port, rsData/rtData read data
module regfile import regfile_pkg::*; #(
  parameter int WIDTH  = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rsNum,
  input  logic [ADDR_W-1:0] rtNum,
  input  logic [ADDR_W-1:0] rdNum,
  input  logic [WIDTH-1:0]  rdData,
  input  logic              rdWriteEnable,
  output logic [WIDTH-1:0]  rsData,
  output logic [WIDTH-1:0]  rtData
);
  localparam int N = 1 << ADDR_W;
  logic [WIDTH-1:0] words [N];
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_word
      if (g == ZERO_REG) begin : g_zero
        assign words[g] = '0;
      end else begin : g_reg
        register #(.WIDTH(WIDTH)) u_reg (
          .clock(clock),
          .reset(reset),
          .load (rdWriteEnable && rdNum == ADDR_W'(g)),
          .d    (rdData),
          .q    (words[g])
        );
      end
    end
  endgenerate
  assign rsData = words[rsNum];
  assign rtData = words[rtNum];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for regfile
module tb_regfile;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  logic        clock = 0;
  logic        reset = 1;
  logic [4:0]  rsNum = 0, rtNum = 0, rdNum = 0;
  logic [31:0] rdData = 0;
  logic        rdWriteEnable = 0;
  logic [31:0] rsData, rtData;
  logic [31:0] mdl [32];
  sb_t         sb [$];
  int          checks = 0, failures = 0;

  regfile dut (
    .clock(clock), .reset(reset), .rsNum(rsNum), .rtNum(rtNum), .rdNum(rdNum),
    .rdData(rdData), .rdWriteEnable(rdWriteEnable), .rsData(rsData), .rtData(rtData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic clr_mdl;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  task automatic rd(input string tag, input int s, input int t);
    sb_t e;
    rsNum = 5'(s);
    rtNum = 5'(t);
    sb.push_back('{tag: $sformatf("%s_rs%0d", tag, s), exp: mdl[s]});
    sb.push_back('{tag: $sformatf("%s_rt%0d", tag, t), exp: mdl[t]});
    #1;
    e = sb.pop_front();
    check(e.tag, rsData, e.exp);
    e = sb.pop_front();
    check(e.tag, rtData, e.exp);
  endtask

  task automatic wr(input int n, input logic [31:0] d);
    rdNum = 5'(n);
    rdData = d;
    rdWriteEnable = 1;
    cyc();
    rdWriteEnable = 0;
    if (n != 0) mdl[n] = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) rd(tag, i, 31 - i);
  endtask

  initial begin
    clr_mdl();
    for (int i = 0; i < 32; i++) mdl[i] = 32'hBAD0_0000 | i;
    cyc();
    reset = 0;
    clr_mdl();
    sweep("reset");
    wr(5, 32'hDEADBEEF);
    rd("wr5", 5, 6);
    wr(0, 32'hFFFFFFFF);
    rd("r0", 0, 0);
    wr(7, 32'h1);
    rdNum = 7;
    rdData = 32'h2;
    rdWriteEnable = 1;
    rd("rdw_pre", 7, 7);
    cyc();
    rdWriteEnable = 0;
    mdl[7] = 32'h2;
    rd("rdw_post", 7, 5);
    wr(9, 32'h5555AAAA);
    rdNum = 9;
    rdData = 32'h1234;
    rdWriteEnable = 0;
    cyc();
    rd("we0", 9, 9);
    reset = 1;
    rdNum = 3;
    rdData = 32'hA5A5A5A5;
    rdWriteEnable = 1;
    cyc();
    reset = 0;
    rdWriteEnable = 0;
    clr_mdl();
    rd("rst_prio", 3, 5);
    sweep("rst_mid");
    for (int i = 1; i < 32; i++) wr(i, $urandom() ^ (32'h0101_0101 * i));
    wr(0, 32'h12345678);
    sweep("fill");
    for (int i = 0; i < 32; i++) rd("same", i, i);
    wr(17, 32'hCAFEF00D);
    rd("one_hot", 17, 16);
    rd("one_hot", 18, 1);
    reset = 1;
    cyc();
    reset = 0;
    clr_mdl();
    sweep("rst_end");
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
